// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory controller.
// Contents:
//   LINE_W, DEPTH       line width and number of lines
//   IDX_LSB, IDX_MSB    byte-address bits that select the line
//   MEM_LATENCY_DEFAULT default request-to-ack latency in clock edges
//   state_e             controller FSM states
package dmem_pkg;

  localparam int unsigned LINE_W              = 256;
  localparam int unsigned DEPTH               = 512;
  localparam int unsigned IDX_LSB             = 5;
  localparam int unsigned IDX_MSB             = 13;
  localparam int unsigned IDX_W               = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned MEM_LATENCY_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

endpackage

// File: rtl/data_memory_ctrl.sv
// Main-memory model behind the L1 data cache: 512 lines x 256 b, whole-line reads and writes
// with a fixed latency and a one-cycle completion pulse.
// Ports:
//   clk_i     clock, all state on posedge
//   rst_i     synchronous active-high reset (does not clear the storage array)
//   addr_i    byte address, line index = addr_i[13:5]
//   data_i    write line
//   enable_i  request valid, held with addr/data/write until ack_o
//   write_i   1 = write line, 0 = read line
//   ack_o     one-cycle completion pulse
//   data_o    last read line, held until the next read completes
//   err_o     (only with DMEM_ERR_EN) flags a misaligned or out-of-range address during ack_o
// Build option: define DMEM_ERR_EN to add err_o and the address check.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef DMEM_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned     CNT_W   = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // Storage is deliberately left without reset so contents survive rst_i.
  logic [LINE_W-1:0] memory [0:DEPTH-1];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] rdata_q;
  logic              access;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    ack_d   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          count_d = CntOne;
          idx_d   = addr_i[IDX_MSB:IDX_LSB];
          wdata_d = data_i;
          write_d = write_i;
        end
      end
      WAIT: begin
        // Access fires on the edge seen with count already at MEM_LATENCY-1.
        if (count_q == CntLast) begin
          access  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          count_d = count_q + CntOne;
        end
      end
      ACK: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ack_q   <= ack_d;
    end
  end

  // Reset on the access edge aborts the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access && write_q) begin
      memory[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (access && !write_q) begin
      rdata_q <= memory[idx_q];
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rdata_q;

`ifdef DMEM_ERR_EN
  logic bad_q, bad_d;
  logic err_q, err_d;

  always_comb begin
    bad_d = bad_q;
    if (state_q == IDLE && enable_i) begin
      bad_d = (|addr_i[31:IDX_MSB+1]) | (|addr_i[IDX_LSB-1:0]);
    end
    err_d = access & bad_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_MSB+1], addr_i[IDX_LSB-1:0]};
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: directed requests push expected ack data into a queue,
// an independent negedge monitor pops and compares on every ack_o.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam int unsigned LAT = 10;
  localparam logic [255:0] BEEF = {8{32'hDEADBEEF}};
  localparam logic [255:0] OLD2 = 256'hA5A5_0002;
  localparam logic [255:0] NEW2 = 256'h1234_5678;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] rdata;
`ifdef DMEM_ERR_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .MEM_LATENCY(LAT)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (addr),
    .data_i  (wdata),
    .enable_i(enable),
    .write_i (write),
    .ack_o   (ack),
    .data_o  (rdata)
`ifdef DMEM_ERR_EN
    ,
    .err_o   (err)
`endif
  );

  typedef struct {
    logic [255:0] data;
    logic         err;
    string        name;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input logic [255:0] got,
                                input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endfunction

  function automatic void push(input string nm, input logic [255:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.name = nm;
    sb.push_back(x);
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack_o=1 required no ack at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"}, rdata, mon_e.data);
`ifdef DMEM_ERR_EN
        check({mon_e.name, "_err"}, 256'(err), 256'(mon_e.err));
`endif
      end
    end
  end

  // Counts edges until ack_o is seen, bounded.
  task automatic wait_ack(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (ack !== 1'b1 && edges < 40);
  endtask

  task automatic txn(input logic [31:0] a, input logic [255:0] d, input logic w,
                     input string nm, input logic [255:0] exp_d, input logic exp_e);
    int edges;
    push(nm, exp_d, exp_e);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    write  = w;
    enable = 1'b1;
    @(posedge clk);  // acceptance edge
    wait_ack(edges);
    check({nm, "_latency"}, 256'(edges), 256'(LAT - 1));
    if (ack !== 1'b1) void'(sb.pop_back());
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_ack_width"}, 256'(ack), 256'(0));
  endtask

  initial begin
    int edges;
    dut.memory[0] = 256'h5;
    dut.memory[1] = 256'h0;
    dut.memory[2] = OLD2;

    // Reset held 2 cycles with a request pending: it must not be accepted.
    rst    = 1'b1;
    enable = 1'b1;
    write  = 1'b0;
    addr   = 32'h0;
    wdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ack", 256'(ack), 256'(0));
    check("reset_data", rdata, 256'h0);
    check("reset_state", 256'(dut.state_q), 256'(IDLE));
    repeat (LAT + 2) @(posedge clk);

    txn(32'h0000_0000, '0, 1'b0, "rd0", 256'h5, 1'b0);
    txn(32'h0000_0020, BEEF, 1'b1, "wr1", 256'h5, 1'b0);
    check("wr1_mem", dut.memory[1], BEEF);
    txn(32'h0000_0020, '0, 1'b0, "rd1", BEEF, 1'b0);
    txn(32'h0000_4020, '0, 1'b0, "rd1_alias", BEEF, 1'b1);
    txn(32'h0000_0021, '0, 1'b0, "rd1_unaligned", BEEF, 1'b1);

    // Reset in the middle of a write: no ack, no store.
    @(negedge clk);
    addr   = 32'h0000_0040;
    wdata  = NEW2;
    write  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    check("abort_mem2", dut.memory[2], OLD2);
    check("abort_state", 256'(dut.state_q), 256'(IDLE));
    check("abort_data", rdata, 256'h0);
    txn(32'h0000_0040, '0, 1'b0, "rd2_after_abort", OLD2, 1'b0);

    // Back-to-back reads with enable_i held high.
    push("b2b_a", 256'h5, 1'b0);
    push("b2b_b", BEEF, 1'b0);
    @(negedge clk);
    addr   = 32'h0000_0000;
    write  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    wait_ack(edges);
    check("b2b_first_latency", 256'(edges), 256'(LAT - 1));
    @(negedge clk);
    addr = 32'h0000_0020;
    wait_ack(edges);
    check("b2b_gap", 256'(edges), 256'(LAT + 1));
    @(negedge clk);
    enable = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
